// File: rtl/gb_oam_dma_pkg.sv
// Shared constants, state encoding and echo-RAM fold helper for the OAM DMA block.
// The interconnect and LCD benches import the state encoding from here too.
package gb_oam_dma_pkg;

  localparam logic [15:0] ADDR_DMA     = 16'hFF46;
  localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_e;

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so fold the high source byte down.
  function automatic logic [7:0] echo_fold(input logic [7:0] hi);
    return (hi >= ECHO_BASE_HI) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/gb_oam_dma_if.sv
// Core bus, DMA source bus and OAM write port seen by the OAM DMA controller.
// The tristate core data bus stays a plain inout port on the controller.
interface gb_oam_dma_if;

  logic [15:0] db_address;
  logic        db_nread;
  logic        db_nwrite;
  logic [15:0] dma_address;
  logic        dma_nread;
  logic [7:0]  dma_rd_data;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;
  logic        oam_nwrite;
  logic        dma_busy;

  modport master (
    output db_address, db_nread, db_nwrite, dma_rd_data,
    input  dma_address, dma_nread, oam_address, oam_data, oam_nwrite, dma_busy
  );

  modport slave (
    input  db_address, db_nread, db_nwrite, dma_rd_data,
    output dma_address, dma_nread, oam_address, oam_data, oam_nwrite, dma_busy
  );

endinterface

// File: rtl/gb_oam_dma.sv
// OAM DMA controller: a write to FF46 copies LENGTH bytes from {XX,00} into OAM,
// one byte per CYCLES_PER_BYTE clocks, after a START_DELAY clock lead-in.
module gb_oam_dma
  import gb_oam_dma_pkg::*;
#(
  parameter int LENGTH          = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic          clock,
  input  logic          reset,
  inout  wire  [7:0]    db_data,
  gb_oam_dma_if.slave   bus
);

  localparam int PH_W  = $clog2(CYCLES_PER_BYTE);
  localparam int DLY_W = $clog2(START_DELAY + 1);
  localparam logic [PH_W-1:0]  PH_CAP   = PH_W'(CYCLES_PER_BYTE - 2);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYCLES_PER_BYTE - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]       IDX_LAST = 8'(LENGTH - 1);

  dma_state_e       state_q, state_d;
  logic [7:0]       src_hi_q, src_hi_d;
  logic [7:0]       idx_q, idx_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             wr_match_q, wr_match_d;
  logic [15:0]      dma_address_q, dma_address_d;
  logic             dma_nread_q, dma_nread_d;
  logic [7:0]       oam_address_q, oam_address_d;
  logic [7:0]       oam_data_q, oam_data_d;
  logic             oam_nwrite_q, oam_nwrite_d;
  logic             busy_q, busy_d;

  logic wr_match;
  logic rd_match;
  logic accept;

  assign wr_match = !bus.db_nwrite && (bus.db_address == ADDR_DMA);
  assign rd_match = !bus.db_nread  && (bus.db_address == ADDR_DMA);
  assign accept   = wr_match && !wr_match_q;

  assign db_data = rd_match ? src_hi_q : 8'hzz;

  always_comb begin
    wr_match_d = wr_match;
    state_d    = state_q;
    src_hi_d   = src_hi_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    dly_d      = dly_q;
    oam_data_d = oam_data_q;

    case (state_q)
      ST_START: begin
        if (dly_q == DLY_LAST) begin
          state_d = ST_XFER;
          idx_d   = 8'd0;
          phase_d = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_XFER: begin
        if (phase_q == PH_CAP) oam_data_d = bus.dma_rd_data;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (idx_q == IDX_LAST) state_d = ST_IDLE;
          else                   idx_d   = idx_q + 8'd1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: ;
    endcase

    // A new FF46 write overrides everything, including the final XFER clock.
    if (accept) begin
      src_hi_d = db_data;
      state_d  = ST_START;
      dly_d    = '0;
      idx_d    = 8'd0;
      phase_d  = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    busy_d        = (state_d != ST_IDLE);
    dma_nread_d   = (state_d != ST_XFER);
    dma_address_d = (state_d == ST_XFER) ? {echo_fold(src_hi_d), idx_d} : dma_address_q;
    oam_nwrite_d  = !((state_d == ST_XFER) && (phase_d == PH_LAST));
    oam_address_d = oam_nwrite_d ? oam_address_q : idx_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_hi_q      <= 8'h00;
      idx_q         <= 8'h00;
      phase_q       <= '0;
      dly_q         <= '0;
      wr_match_q    <= 1'b0;
      dma_address_q <= 16'h0000;
      dma_nread_q   <= 1'b1;
      oam_address_q <= 8'h00;
      oam_data_q    <= 8'h00;
      oam_nwrite_q  <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_hi_q      <= src_hi_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      dly_q         <= dly_d;
      wr_match_q    <= wr_match_d;
      dma_address_q <= dma_address_d;
      dma_nread_q   <= dma_nread_d;
      oam_address_q <= oam_address_d;
      oam_data_q    <= oam_data_d;
      oam_nwrite_q  <= oam_nwrite_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.dma_address = dma_address_q;
  assign bus.dma_nread   = dma_nread_q;
  assign bus.oam_address = oam_address_q;
  assign bus.oam_data    = oam_data_q;
  assign bus.oam_nwrite  = oam_nwrite_q;
  assign bus.dma_busy    = busy_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: directed FF46 writes, expected OAM writes and busy lengths
// queued at stimulus time and checked by independent monitors.
module tb_gb_oam_dma;

  typedef struct {
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic [15:0] src_addr;
  } oam_txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gb_oam_dma_if bus ();

  tri1  [7:0] db_data;
  logic [7:0] tb_drv;
  logic       tb_drv_en;
  assign db_data = tb_drv_en ? tb_drv : 8'hzz;

  gb_oam_dma dut (
    .clock   (clk),
    .reset   (reset),
    .db_data (db_data),
    .bus     (bus.slave)
  );

  // Source memory: registered, returns low address byte ^ 5A.
  always @(posedge clk) begin
    bus.dma_rd_data <= bus.dma_address[7:0] ^ 8'h5A;
  end

  int checks = 0;
  int errors = 0;
  oam_txn_t exp_q[$];
  int       busy_q[$];
  int       busy_run = 0;
  logic     acc_mark = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected OAM writes for n bytes read from page eff_hi (already echo-folded).
  task automatic push_xfer(input logic [7:0] eff_hi, input int n);
    for (int i = 0; i < n; i++) begin
      oam_txn_t t;
      t.oam_addr = 8'(i);
      t.oam_data = 8'(i) ^ 8'h5A;
      t.src_addr = {eff_hi, 8'(i)};
      exp_q.push_back(t);
    end
  endtask

  // OAM write monitor.
  always @(negedge clk) begin
    if (!reset && bus.oam_nwrite === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL oam_unexpected: got idx=%0d data=%02h expected no write",
                 bus.oam_address, bus.oam_data);
      end else begin
        oam_txn_t t;
        t = exp_q.pop_front();
        $display("OAM idx=%0d data=%02h src=%04h", bus.oam_address, bus.oam_data, bus.dma_address);
        chk("oam_address", 32'(bus.oam_address), 32'(t.oam_addr));
        chk("oam_data",    32'(bus.oam_data),    32'(t.oam_data));
        chk("dma_address", 32'(bus.dma_address), 32'(t.src_addr));
      end
    end
  end

  // Busy-length monitor; an accepted write restarts the count.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
      acc_mark = 1'b0;
    end else begin
      if (bus.dma_busy === 1'b1) begin
        busy_run = acc_mark ? 1 : busy_run + 1;
      end else if (busy_run != 0) begin
        if (busy_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_unexpected: got run of %0d expected none", busy_run);
        end else begin
          int e;
          e = busy_q.pop_front();
          $display("BUSY run=%0d", busy_run);
          chk("busy_len", 32'(busy_run), 32'(e));
        end
        busy_run = 0;
      end
      acc_mark = 1'b0;
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.db_address = a;
    bus.db_nwrite  = 1'b0;
    tb_drv         = d;
    tb_drv_en      = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      if (k == 0 && a == 16'hFF46) acc_mark = 1'b1;
    end
    @(negedge clk);
    bus.db_nwrite  = 1'b1;
    tb_drv_en      = 1'b0;
    bus.db_address = 16'h0000;
    $display("WR %04h <= %02h hold=%0d", a, d, hold);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.db_address = a;
    bus.db_nread   = 1'b0;
    #1;
    $display("RD %04h -> %02h", a, db_data);
    chk(name, 32'(db_data), 32'(exp));
    bus.db_nread   = 1'b1;
    bus.db_address = 16'h0000;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.dma_busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy after %0d clocks expected idle", name, n);
    end
  endtask

  task automatic wait_oam(input logic [7:0] idx, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.oam_nwrite === 1'b0 && bus.oam_address == idx) && n < 2000);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s: got no write to idx %0d expected one", name, idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.db_address = 16'h0000;
    bus.db_nread   = 1'b1;
    bus.db_nwrite  = 1'b1;
    tb_drv         = 8'h00;
    tb_drv_en      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",        32'(bus.dma_busy),    32'h0);
    chk("rst_dma_nread",   32'(bus.dma_nread),   32'h1);
    chk("rst_dma_address", 32'(bus.dma_address), 32'h0);
    chk("rst_oam_nwrite",  32'(bus.oam_nwrite),  32'h1);
    chk("rst_oam_address", 32'(bus.oam_address), 32'h0);
    chk("rst_oam_data",    32'(bus.oam_data),    32'h0);
    cpu_read(16'hFF46, 8'h00, "rst_src_hi");

    // Case 1 + 3: full transfer from C100, readback during and after.
    push_xfer(8'hC1, 160);
    busy_q.push_back(644);
    cpu_write(16'hFF46, 8'hC1, 1);
    repeat (100) @(negedge clk);
    cpu_read(16'hFF46, 8'hC1, "rd_busy");
    wait_idle("idle_c1");
    cpu_read(16'hFF46, 8'hC1, "rd_after");
    cpu_read(16'hFF47, 8'hFF, "rd_ff47_z");
    @(negedge clk);
    bus.db_address = 16'hFF46;
    #1;
    chk("idle_z", 32'(db_data), 32'hFF);
    bus.db_address = 16'h0000;

    // Case 2: held strobe is one write; FF47 write does nothing.
    push_xfer(8'hC3, 160);
    busy_q.push_back(644);
    cpu_write(16'hFF46, 8'hC3, 3);
    wait_idle("idle_hold");
    cpu_write(16'hFF47, 8'h55, 1);
    repeat (20) @(negedge clk);
    chk("ff47_busy", 32'(bus.dma_busy), 32'h0);
    cpu_read(16'hFF46, 8'hC3, "rd_after_ff47");

    // Case 4: restart mid-transfer from D000.
    push_xfer(8'hC1, 50);
    busy_q.push_back(644);
    cpu_write(16'hFF46, 8'hC1, 1);
    wait_oam(8'd49, "wait_byte49");
    push_xfer(8'hD0, 160);
    cpu_write(16'hFF46, 8'hD0, 1);
    wait_idle("idle_restart");

    // Case 5: echo page E2 reads from C200.
    push_xfer(8'hC2, 160);
    busy_q.push_back(644);
    cpu_write(16'hFF46, 8'hE2, 1);
    wait_idle("idle_echo");

    // Case 6: reset at byte 80, then a clean transfer.
    push_xfer(8'hC1, 80);
    cpu_write(16'hFF46, 8'hC1, 1);
    wait_oam(8'd79, "wait_byte79");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",       32'(bus.dma_busy),   32'h0);
    chk("abort_dma_nread",  32'(bus.dma_nread),  32'h1);
    chk("abort_oam_nwrite", 32'(bus.oam_nwrite), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("abort_drained", 32'(exp_q.size()), 32'h0);
    cpu_read(16'hFF46, 8'h00, "rd_after_reset");
    push_xfer(8'h42, 160);
    busy_q.push_back(644);
    cpu_write(16'hFF46, 8'h42, 1);
    wait_idle("idle_post_reset");

    repeat (10) @(negedge clk);
    chk("sb_empty",   32'(exp_q.size()),  32'h0);
    chk("busy_empty", 32'(busy_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
